// File: rtl/counter_cmd_arbiter.sv
// counter_cmd_arbiter
// Shares one signed up/down counter between two command requesters. A
// round-robin arbiter grants one request per IDLE cycle. The command is latched,
// executed in EXEC, and answered with a one-cycle response tagged with the
// requester id. UP and DN results that would leave the signed range are
// rejected and leave the counter unchanged; there is no wrap and no clamp.
//
// Ports
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   reqN_valid/op/data        command from port N (op: 00 READ, 01 LOAD, 10 UP, 11 DN)
//   reqN_ready                grant to port N this cycle (combinational, IDLE only)
//   q                         signed counter value (registered)
//   rsp_valid/rsp_id/rsp_ok   one-cycle response: requester id, 1 = applied
//   busy                      high while a latched command is executing
module counter_cmd_arbiter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic [WIDTH-1:0] q,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic             rsp_ok,
    output logic             busy
);

    localparam int unsigned OP_W = 2;
    localparam int unsigned EXT_W = WIDTH + 1;

    localparam logic [OP_W-1:0] OP_READ = 2'b00;
    localparam logic [OP_W-1:0] OP_LOAD = 2'b01;
    localparam logic [OP_W-1:0] OP_UP   = 2'b10;
    localparam logic [OP_W-1:0] OP_DN   = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    state_t          state;
    logic            rr_ptr;
    logic [OP_W-1:0] cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic            cmd_id;

    logic             gnt_any_c;
    logic             gnt_id_c;
    logic [OP_W-1:0]  gnt_op_c;
    logic [WIDTH-1:0] gnt_data_c;

    // Grant selection: rr_ptr only matters when both ports are asking.
    always_comb begin
        gnt_any_c  = (state == IDLE) && (req0_valid || req1_valid);
        gnt_id_c   = (req0_valid && req1_valid) ? rr_ptr : req1_valid;
        gnt_op_c   = gnt_id_c ? req1_op : req0_op;
        gnt_data_c = gnt_id_c ? req1_data : req0_data;
    end

    assign req0_ready = gnt_any_c && !gnt_id_c;
    assign req1_ready = gnt_any_c && gnt_id_c;
    assign busy       = (state == EXEC);

    logic [EXT_W-1:0] q_ext_c;
    logic [EXT_W-1:0] d_ext_c;
    logic [EXT_W-1:0] sum_c;
    logic [EXT_W-1:0] diff_c;
    logic             sum_fits_c;
    logic             diff_fits_c;
    logic [WIDTH-1:0] q_next_c;
    logic             ok_c;

    // Execute the latched command one bit wider; the result fits in WIDTH
    // signed bits exactly when the two top bits of the wide result agree.
    always_comb begin
        q_ext_c     = {q[WIDTH-1], q};
        d_ext_c     = {cmd_data[WIDTH-1], cmd_data};
        sum_c       = EXT_W'(q_ext_c + d_ext_c);
        diff_c      = EXT_W'(q_ext_c - d_ext_c);
        sum_fits_c  = (sum_c[WIDTH] == sum_c[WIDTH-1]);
        diff_fits_c = (diff_c[WIDTH] == diff_c[WIDTH-1]);
        q_next_c    = q;
        ok_c        = 1'b1;
        case (cmd_op)
            OP_READ: begin
                q_next_c = q;
                ok_c     = 1'b1;
            end
            OP_LOAD: begin
                q_next_c = cmd_data;
                ok_c     = 1'b1;
            end
            OP_UP: begin
                ok_c = sum_fits_c;
                if (sum_fits_c) begin
                    q_next_c = sum_c[WIDTH-1:0];
                end
            end
            OP_DN: begin
                ok_c = diff_fits_c;
                if (diff_fits_c) begin
                    q_next_c = diff_c[WIDTH-1:0];
                end
            end
            default: begin
                q_next_c = q;
                ok_c     = 1'b1;
            end
        endcase
    end

    // Control FSM with registered counter and response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= 1'b0;
            cmd_op    <= OP_READ;
            cmd_data  <= '0;
            cmd_id    <= 1'b0;
            q         <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_ok    <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (gnt_any_c) begin
                        cmd_op   <= gnt_op_c;
                        cmd_data <= gnt_data_c;
                        cmd_id   <= gnt_id_c;
                        rr_ptr   <= ~gnt_id_c;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    q         <= q_next_c;
                    rsp_valid <= 1'b1;
                    rsp_id    <= cmd_id;
                    rsp_ok    <= ok_c;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_cmd_arbiter.sv
// Directed bench for counter_cmd_arbiter with a response scoreboard and a
// small reference model of the counter and round-robin pointer.
module tb_counter_cmd_arbiter;

    localparam int unsigned WIDTH = 8;
    localparam logic [1:0] OP_READ = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_UP   = 2'b10;
    localparam logic [1:0] OP_DN   = 2'b11;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_valid;
    logic [1:0]       req0_op;
    logic [WIDTH-1:0] req0_data;
    logic             req0_ready;
    logic             req1_valid;
    logic [1:0]       req1_op;
    logic [WIDTH-1:0] req1_data;
    logic             req1_ready;
    logic [WIDTH-1:0] q;
    logic             rsp_valid;
    logic             rsp_id;
    logic             rsp_ok;
    logic             busy;

    always #5 clk = ~clk;

    counter_cmd_arbiter #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_op    (req0_op),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_op    (req1_op),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .q          (q),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_ok     (rsp_ok),
        .busy       (busy)
    );

    typedef struct packed {
        logic             id;
        logic             ok;
        logic [WIDTH-1:0] q;
    } rsp_t;

    rsp_t             sbq[$];
    logic [WIDTH-1:0] mq;
    logic             mrr;
    int               total = 0;
    int               bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference execution of one granted command; pushes the expected response.
    task automatic model_exec(input logic id, input logic [1:0] op, input logic [WIDTH-1:0] d);
        int   s;
        int   lo;
        int   hi;
        logic ok;
        rsp_t r;
        lo = -(1 <<< (WIDTH - 1));
        hi = (1 <<< (WIDTH - 1)) - 1;
        ok = 1'b1;
        s  = 0;
        case (op)
            OP_LOAD: mq = d;
            OP_UP, OP_DN: begin
                if (op == OP_UP) s = int'($signed(mq)) + int'($signed(d));
                else             s = int'($signed(mq)) - int'($signed(d));
                if (s < lo || s > hi) ok = 1'b0;
                else                  mq = WIDTH'(s);
            end
            default: ;
        endcase
        r.id = id;
        r.ok = ok;
        r.q  = mq;
        sbq.push_back(r);
    endtask

    // Called in an IDLE cycle after inputs are driven: predict and check the grant.
    task automatic arb(input string tag);
        logic any;
        logic g;
        #1;
        any = req0_valid || req1_valid;
        g   = (req0_valid && req1_valid) ? mrr : req1_valid;
        chk({tag, "_ready0"}, 32'(req0_ready), 32'(any && !g));
        chk({tag, "_ready1"}, 32'(req1_ready), 32'(any && g));
        if (any) begin
            if (g) model_exec(1'b1, req1_op, req1_data);
            else   model_exec(1'b0, req0_op, req0_data);
            mrr = ~g;
        end
    endtask

    // Advance one cycle; any response seen is checked against the scoreboard.
    task automatic tick();
        rsp_t r;
        @(posedge clk);
        @(negedge clk);
        if (rsp_valid === 1'b1) begin
            chk("rsp_expected", 32'(sbq.size() != 0), 32'd1);
            if (sbq.size() != 0) begin
                r = sbq.pop_front();
                chk("rsp_id", 32'(rsp_id), 32'(r.id));
                chk("rsp_ok", 32'(rsp_ok), 32'(r.ok));
                chk("rsp_q", 32'(q), 32'(r.q));
            end
        end
    endtask

    task automatic drive(input logic v0, input logic [1:0] o0, input logic [WIDTH-1:0] d0,
                         input logic v1, input logic [1:0] o1, input logic [WIDTH-1:0] d1);
        req0_valid = v0;
        req0_op    = o0;
        req0_data  = d0;
        req1_valid = v1;
        req1_op    = o1;
        req1_data  = d1;
    endtask

    // One command from a single port, with the EXEC cycle checked.
    task automatic issue(input string tag, input logic p, input logic [1:0] op,
                         input logic [WIDTH-1:0] d);
        if (p) drive(1'b0, OP_READ, '0, 1'b1, op, d);
        else   drive(1'b1, op, d, 1'b0, OP_READ, '0);
        arb(tag);
        tick();
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        chk({tag, "_exec_rdy"}, 32'({req0_ready, req1_ready}), 32'd0);
        drive(1'b0, OP_READ, '0, 1'b0, OP_READ, '0);
        tick();
        chk({tag, "_drained"}, 32'(sbq.size()), 32'd0);
        chk({tag, "_q"}, 32'(q), 32'(mq));
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, OP_READ, '0, 1'b0, OP_READ, '0);
        mq  = '0;
        mrr = 1'b0;
        tick();
        tick();
        chk("reset_q", 32'(q), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_id", 32'(rsp_id), 32'd0);
        chk("reset_rsp_ok", 32'(rsp_ok), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        rst = 1'b0;

        // Positive edge of the range.
        issue("load100", 1'b0, OP_LOAD, 8'd100);
        issue("up27", 1'b0, OP_UP, 8'd27);
        chk("q_127", 32'(q), 32'd127);
        issue("up1_reject", 1'b0, OP_UP, 8'd1);
        chk("q_stays_127", 32'(q), 32'd127);

        // Negative edge of the range.
        issue("load_m128", 1'b0, OP_LOAD, 8'h80);
        issue("dn1_reject", 1'b0, OP_DN, 8'd1);
        issue("up_m1_reject", 1'b0, OP_UP, 8'hFF);
        chk("q_stays_m128", 32'(q), 32'h80);
        issue("dn_m5", 1'b0, OP_DN, 8'hFB);
        chk("q_m123", 32'(q), 32'(8'h85));

        // Port 1 READ; during its EXEC both ports raise requests, then port 0
        // withdraws before the next grant and must never execute.
        drive(1'b0, OP_READ, '0, 1'b1, OP_READ, '0);
        arb("p1_read");
        tick();
        chk("p1_read_busy", 32'(busy), 32'd1);
        drive(1'b1, OP_LOAD, 8'd99, 1'b1, OP_UP, 8'd3);
        #1;
        chk("exec_ignores", 32'({req0_ready, req1_ready}), 32'd0);
        tick();
        chk("p1_read_q", 32'(q), 32'(8'h85));
        req0_valid = 1'b0;
        arb("drop_p0");
        tick();
        drive(1'b0, OP_READ, '0, 1'b0, OP_READ, '0);
        tick();
        tick();
        chk("drop_drained", 32'(sbq.size()), 32'd0);
        chk("drop_q", 32'(q), 32'(8'h88));

        // Reset during EXEC discards the command.
        drive(1'b1, OP_LOAD, 8'd55, 1'b0, OP_READ, '0);
        #1;
        chk("rx_ready0", 32'(req0_ready), 32'd1);
        tick();
        chk("rx_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        drive(1'b0, OP_READ, '0, 1'b0, OP_READ, '0);
        tick();
        chk("rx_no_rsp", 32'(rsp_valid), 32'd0);
        chk("rx_q", 32'(q), 32'd0);
        chk("rx_busy_low", 32'(busy), 32'd0);
        mq  = '0;
        mrr = 1'b0;
        rst = 1'b0;
        tick();
        chk("rx_still_no_rsp", 32'(rsp_valid), 32'd0);

        // Both ports hold UP 1: grants alternate starting at port 0, 2 cycles each.
        drive(1'b1, OP_UP, 8'd1, 1'b1, OP_UP, 8'd1);
        for (int i = 0; i < 8; i++) begin
            arb("fair");
            tick();
            chk("fair_busy", 32'(busy), 32'd1);
            chk("fair_exec_rdy", 32'({req0_ready, req1_ready}), 32'd0);
            tick();
            chk("fair_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("fair_rsp_id", 32'(rsp_id), 32'(i % 2));
        end
        drive(1'b0, OP_READ, '0, 1'b0, OP_READ, '0);
        tick();
        chk("fair_drained", 32'(sbq.size()), 32'd0);
        chk("fair_q", 32'(q), 32'd8);
        tick();
        chk("idle_no_rsp", 32'(rsp_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
